// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_pkg
// Purpose  : Mode encodings and width helper shared by the decoder_seq slice.
// Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_SCAN  = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    function automatic int out_width(input int n);
        return 1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_seq_scan_tick.sv
`default_nettype none
// ============================================================================
// Module   : scan_tick
// Purpose  : Prescaler counting 0..DIV-1; tick marks the last count of a hold.
// Revision : 1.0 - initial release
// ============================================================================
module scan_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int             CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  c_last = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = en && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_seq
// Purpose  : Registered N-to-2^N one-hot decoder with LEVEL, PULSE and SCAN modes.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int N        = 5,
    parameter int SCAN_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic [N-1:0]              in,
    input  logic                      in_valid,
    output logic [out_width(N)-1:0]   out,
    output logic                      out_valid,
    output logic [N-1:0]              idx
);

    localparam int            W     = out_width(N);
    localparam logic [W-1:0]  c_one = W'(1);

    logic [1:0]   r_prev_mode;
    logic         r_level_valid;
    logic [N-1:0] r_level_idx;
    logic [N-1:0] r_scan_cnt;

    logic         w_mode_chg;
    logic         w_scan_run;
    logic         w_tick;
    logic         w_sel_valid;
    logic [N-1:0] w_sel_idx;

    assign w_mode_chg = (mode != r_prev_mode);
    assign w_scan_run = en && (mode == MODE_SCAN) && !w_mode_chg;

    scan_tick #(
        .DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (w_mode_chg),
        .en    (w_scan_run),
        .tick  (w_tick)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        if (en && !w_mode_chg) begin
            case (mode)
                MODE_LEVEL: begin
                    if (in_valid) begin
                        w_sel_valid = 1'b1;
                        w_sel_idx   = in;
                    end else begin
                        w_sel_valid = r_level_valid;
                        w_sel_idx   = r_level_idx;
                    end
                end
                MODE_PULSE: begin
                    w_sel_valid = in_valid;
                    w_sel_idx   = in;
                end
                MODE_SCAN: begin
                    w_sel_valid = 1'b1;
                    w_sel_idx   = r_scan_cnt;
                end
                default: begin
                    w_sel_valid = 1'b0;
                    w_sel_idx   = '0;
                end
            endcase
        end
    end

    // Reset leaves the previous mode at LEVEL, so releasing reset in any other
    // mode first produces one mode-change cycle. A mode change also overrides en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_mode   <= MODE_LEVEL;
            r_level_valid <= 1'b0;
            r_level_idx   <= '0;
            r_scan_cnt    <= '0;
            out           <= '0;
            out_valid     <= 1'b0;
            idx           <= '0;
        end else begin
            r_prev_mode <= mode;
            if (w_mode_chg) begin
                r_level_valid <= 1'b0;
                r_level_idx   <= '0;
                r_scan_cnt    <= '0;
            end else begin
                if (en && (mode == MODE_LEVEL) && in_valid) begin
                    r_level_valid <= 1'b1;
                    r_level_idx   <= in;
                end
                if (w_tick) begin
                    r_scan_cnt <= r_scan_cnt + 1'b1;
                end
            end
            out       <= w_sel_valid ? (c_one << w_sel_idx) : '0;
            out_valid <= w_sel_valid;
            idx       <= w_sel_valid ? w_sel_idx : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_seq
// Purpose  : Directed and randomized self-checking bench for decoder_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [4:0]  in5;
    logic [2:0]  in3;
    logic        in_valid;
    logic [31:0] out5;
    logic        out_valid5;
    logic [4:0]  idx5;
    logic [7:0]  out3;
    logic        out_valid3;
    logic [2:0]  idx3;

    int errors = 0;
    int checks = 0;

    assign in3 = in5[2:0];

    always #5 clk = ~clk;

    decoder_seq #(.N(5), .SCAN_DIV(4)) u_dut5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in5), .in_valid(in_valid),
        .out(out5), .out_valid(out_valid5), .idx(idx5)
    );

    decoder_seq #(.N(3), .SCAN_DIV(2)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in3), .in_valid(in_valid),
        .out(out3), .out_valid(out_valid3), .idx(idx3)
    );

    // Reference model state for the N=5, SCAN_DIV=4 instance
    logic [1:0] m_prev;
    logic       m_lv;
    logic [4:0] m_li;
    logic [4:0] m_cnt;
    int         m_pre;
    logic       m_v;
    logic [4:0] m_i;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_prev = 2'b00; m_lv = 1'b0; m_li = '0; m_cnt = '0; m_pre = 0;
            m_v = 1'b0; m_i = '0;
        end else if (mode != m_prev) begin
            m_prev = mode; m_lv = 1'b0; m_li = '0; m_cnt = '0; m_pre = 0;
            m_v = 1'b0; m_i = '0;
        end else if (!en) begin
            m_v = 1'b0; m_i = '0;
        end else begin
            m_v = 1'b0; m_i = '0;
            if (mode == 2'b00) begin
                if (in_valid) begin m_lv = 1'b1; m_li = in5; end
                m_v = m_lv; m_i = m_lv ? m_li : 5'd0;
            end else if (mode == 2'b01) begin
                m_v = in_valid; m_i = in_valid ? in5 : 5'd0;
            end else if (mode == 2'b10) begin
                m_v = 1'b1; m_i = m_cnt;
                if (m_pre == 3) begin m_pre = 0; m_cnt = m_cnt + 5'd1; end
                else m_pre = m_pre + 1;
            end
        end
    endtask

    initial begin
        logic [7:0]  e3;
        logic [31:0] e5;

        rst = 1'b1; en = 1'b0; mode = 2'b00; in5 = '0; in_valid = 1'b0;
        step(); step();
        check("reset_out",   64'(out5), 64'h0);
        check("reset_idx",   64'(idx5), 64'h0);
        check("reset_valid", 64'(out_valid5), 64'h0);

        // LEVEL
        rst = 1'b0; en = 1'b1;
        step();
        check("level_idle", 64'({out5, idx5, out_valid5}), 64'h0);
        in5 = 5'd19; in_valid = 1'b1;
        step();
        check("level_cap", 64'({out5, idx5, out_valid5}), 64'({32'h0008_0000, 5'd19, 1'b1}));
        in_valid = 1'b0; in5 = 5'd3;
        step();
        check("level_hold1", 64'({out5, idx5, out_valid5}), 64'({32'h0008_0000, 5'd19, 1'b1}));
        step();
        check("level_hold2", 64'({out5, idx5, out_valid5}), 64'({32'h0008_0000, 5'd19, 1'b1}));

        // PULSE; the input on the mode-change edge is discarded
        mode = 2'b01; in5 = 5'd19; in_valid = 1'b1;
        step();
        check("pulse_modechg", 64'({out5, idx5, out_valid5}), 64'h0);
        in5 = 5'd0;  step(); check("pulse_0",  64'({out5, idx5, out_valid5}), 64'({32'h0000_0001, 5'd0, 1'b1}));
        in5 = 5'd31; step(); check("pulse_31", 64'({out5, idx5, out_valid5}), 64'({32'h8000_0000, 5'd31, 1'b1}));
        in5 = 5'd7;  step(); check("pulse_7",  64'({out5, idx5, out_valid5}), 64'({32'h0000_0080, 5'd7, 1'b1}));
        in_valid = 1'b0;
        step(); check("pulse_end", 64'({out5, idx5, out_valid5}), 64'h0);

        // SCAN on the N=3, SCAN_DIV=2 instance
        mode = 2'b10;
        step(); check("scan_entry", 64'({out3, idx3, out_valid3}), 64'h0);
        for (int k = 0; k < 8; k++) begin
            e3 = 8'h01 << k;
            for (int r = 0; r < 2; r++) begin
                step();
                check("scan_walk", 64'({out3, idx3, out_valid3}), 64'({e3, 3'(k), 1'b1}));
            end
        end
        step(); check("scan_wrap_a", 64'({out3, idx3, out_valid3}), 64'({8'h01, 3'd0, 1'b1}));
        step(); check("scan_wrap_b", 64'({out3, idx3, out_valid3}), 64'({8'h01, 3'd0, 1'b1}));
        step(); check("scan_wrap_c", 64'({out3, idx3, out_valid3}), 64'({8'h02, 3'd1, 1'b1}));
        step(); step(); step(); step();
        check("scan_idx3", 64'({out3, idx3, out_valid3}), 64'({8'h08, 3'd3, 1'b1}));

        // Pause after the first of the two idx=3 cycles
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("scan_pause", 64'({out3, idx3, out_valid3}), 64'h0);
        end
        en = 1'b1;
        step(); check("scan_resume3", 64'({out3, idx3, out_valid3}), 64'({8'h08, 3'd3, 1'b1}));
        step(); check("scan_resume4", 64'({out3, idx3, out_valid3}), 64'({8'h10, 3'd4, 1'b1}));

        // Reset mid-scan: one mode-change cycle after release, then index 0
        rst = 1'b1;
        step(); check("scan_rst", 64'({out3, idx3, out_valid3}), 64'h0);
        rst = 1'b0;
        step(); check("scan_rst_chg", 64'({out3, idx3, out_valid3}), 64'h0);
        step(); check("scan_restart0", 64'({out3, idx3, out_valid3}), 64'({8'h01, 3'd0, 1'b1}));
        step(); check("scan_restart0b", 64'({out3, idx3, out_valid3}), 64'({8'h01, 3'd0, 1'b1}));
        step(); check("scan_restart1", 64'({out3, idx3, out_valid3}), 64'({8'h02, 3'd1, 1'b1}));

        // Reset during a PULSE in_valid
        mode = 2'b01;
        step();
        in5 = 5'd5; in_valid = 1'b1;
        step(); check("pulse_pre_rst", 64'({out5, idx5, out_valid5}), 64'({32'h0000_0020, 5'd5, 1'b1}));
        rst = 1'b1;
        step(); check("pulse_rst", 64'({out5, idx5, out_valid5}), 64'h0);
        rst = 1'b0; in_valid = 1'b0;
        step(); check("pulse_after_rst", 64'({out5, idx5, out_valid5}), 64'h0);

        // Randomized stress against the reference model
        rst = 1'b1;
        model_step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            in5      = 5'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            model_step();
            step();
            e5 = m_v ? (32'h1 << m_i) : 32'h0;
            check("rand_model", 64'({out5, idx5, out_valid5}), 64'({e5, m_i, m_v}));
            check("rand_onehot", 64'(($countones(out5) <= 1) && ($countones(out3) <= 1)), 64'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_seq.md
# decoder_seq

Parametrised, registered N-to-2^N one-hot decoder with three operating modes: level decode, single-cycle pulse decode, and free-running scan. It is the sequential successor to the fixed 5x32 combinational decoder. It drives row/column selects, chip-selects and display/keypad scan lines from a single clocked block. All outputs are registered, so downstream select lines are glitch-free.

## Interface
Parameters:
- N, 5, select width; output width is 2**N (N=1..6 supported)
- SCAN_DIV, 4, clock cycles each index is held in SCAN mode (>=1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; 0 forces outputs low and freezes the scan state
- mode  in  2  00 LEVEL, 01 PULSE, 10 SCAN, 11 reserved
- in  in  N  select index (LEVEL/PULSE)
- in_valid  in  1  qualifies `in`; a new index is accepted only when high
- out  out  2**N  registered one-hot output (or all-zero)
- out_valid  out  1  high whenever `out` is non-zero
- idx  out  N  binary index currently asserted on `out` (0 when out is zero)

## Operation
- Reset: out=0, out_valid=0, idx=0, scan counter=0, prescaler=0. Reset overrides every other input.
- en=0: next edge out=0, out_valid=0, idx=0. Scan counter and prescaler hold their values. The captured LEVEL index is retained.
- LEVEL (00): on an edge with en & in_valid, the block captures `in`, and out becomes 1<<in. Without in_valid, out holds the last captured decode. Out stays 0 after reset until the first valid capture.
- PULSE (01): on an edge with en & in_valid, out=1<<in for exactly one cycle, then returns to 0. Back-to-back in_valid gives a continuous stream of one-cycle decodes, one per cycle, each reflecting its own `in`.
- SCAN (10): the internal counter walks 0,1,...,2**N-1 and wraps to 0. Each value is held SCAN_DIV cycles. out=1<<counter. `in` and in_valid are ignored.
- Reserved (11): out=0, out_valid=0, all state held.
- Mode change (any edge where mode differs from the previous cycle's mode): the scan counter and prescaler clear to 0 and the LEVEL capture clears. Out is 0 for that one cycle, then the new mode takes effect from the next edge.
- Invariant: out is always one-hot or zero. popcount(out)<=1 every cycle.

## Timing
- Latency: 1 cycle from a sampled input to out/idx/out_valid. There is no combinational path from input to output.
- SCAN from mode entry:
  - The first edge after the mode change gives out=0 (mode-change cycle).
  - The following SCAN_DIV edges give out=1<<0, then index 1, and so on.
  - The wrap from 2**N-1 to 0 takes exactly SCAN_DIV cycles, with no extra cycle.
- SCAN_DIV=1: the index advances every cycle.
- en deasserted mid-scan: out=0 while en=0. On re-enable, the scan resumes at the held index with the held prescaler count.
- Reset asserted mid-pulse or mid-scan: on that edge all state goes to reset values, and the pending pulse is dropped.
- in_valid together with a mode change on the same edge: the mode change wins, out=0, and the input is discarded.

## Structure
- A shared package `decoder_pkg` holds:
  - the mode encodings MODE_LEVEL=2'b00, MODE_PULSE=2'b01, MODE_SCAN=2'b10, MODE_RSVD=2'b11
  - the helper constant function for the output width, 2**N
- One sub-module, `scan_tick`: a prescaler counting 0..SCAN_DIV-1 that emits a one-cycle `tick`. It has hold (en=0) and clear (mode change/reset) inputs. The scan counter increments on `tick`.
- The top level holds the mode-change detector (registered previous mode), the LEVEL capture register, the scan counter, and the output register stage.

## Test plan
- Reset then LEVEL, N=5: en=1, in_valid pulse with in=5'd19 -> next cycle out=32'h0008_0000, idx=19, out_valid=1. out holds after in_valid drops.
- PULSE: in_valid high for 3 consecutive cycles with in=0,31,7 -> out=32'h1, then 32'h8000_0000, then 32'h80, then 0 on the fourth cycle.
- SCAN, N=3, SCAN_DIV=2: enter mode -> 1 cycle of out=0, then each of 8'h01,02,04,...,80 for 2 cycles, then wrap to 8'h01. The wrap gap is exactly 2 cycles.
- SCAN pause: drop en while idx=3 for 5 cycles -> out=0 for 5 cycles. Re-enable -> idx=3 resumes with the remaining prescaler count preserved.
- Reset mid-operation: assert rst during a PULSE-mode in_valid and during a SCAN hold -> out=0, idx=0, out_valid=0 on that edge. The scan restarts at index 0 after rst releases.
- Random stress: $random mode/en/in/in_valid for 2000 cycles against a reference model -> exact match every cycle, and popcount(out)<=1 always holds.
